// File: rtl/classifier_stream_wrapper.sv
// rtl/classifier_stream_wrapper.sv - AXI-Stream classifier wrapper: per-frame PASS or signed ARGMAX behind a 2-entry skid buffer
module classifier_stream_wrapper #(
    parameter int DATA_WIDTH  = 32,
    parameter int KEEP_WIDTH  = DATA_WIDTH / 8,
    parameter int MAX_CLASSES = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cfg_mode,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
    input  logic                  s_axis_tvalid,
    output logic                  s_axis_tready,
    input  logic                  s_axis_tlast,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic [31:0]           stat_frame_count,
    output logic                  stat_overflow
);

    localparam int IDX_WIDTH = $clog2(MAX_CLASSES);
    localparam int CNT_WIDTH = IDX_WIDTH + 1;
    localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(MAX_CLASSES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE   = CNT_WIDTH'(1);

    logic                  r_s_ready;
    logic                  r_out_valid;
    logic [DATA_WIDTH-1:0] r_out_data;
    logic [KEEP_WIDTH-1:0] r_out_keep;
    logic                  r_out_last;
    logic                  r_skid_valid;
    logic [DATA_WIDTH-1:0] r_skid_data;
    logic [KEEP_WIDTH-1:0] r_skid_keep;
    logic                  r_skid_last;

    logic                  r_sof;
    logic                  r_mode;
    logic [CNT_WIDTH-1:0]  r_beat_cnt;
    logic [DATA_WIDTH-1:0] r_best;
    logic [IDX_WIDTH-1:0]  r_best_idx;
    logic [31:0]           r_frame_count;
    logic                  r_overflow;

    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_frame_mode;
    logic                  w_in_range;
    logic                  w_better;
    logic                  w_ovf_beat;
    logic [DATA_WIDTH-1:0] w_best_next;
    logic [IDX_WIDTH-1:0]  w_idx_next;
    logic [CNT_WIDTH-1:0]  w_cnt_next;
    logic                  w_push;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [KEEP_WIDTH-1:0] w_push_keep;
    logic                  w_push_last;
    logic                  w_skid_valid_next;

    // Classification of the current input beat; the first beat of a frame uses cfg_mode directly
    always_comb begin
        w_in_fire    = s_axis_tvalid && r_s_ready;
        w_out_fire   = r_out_valid && m_axis_tready;
        w_frame_mode = r_sof ? cfg_mode : r_mode;
        w_in_range   = r_beat_cnt < CNT_LIMIT;
        w_better     = $signed(s_axis_tdata) > $signed(r_best);
        w_ovf_beat   = !r_sof && !w_in_range;
        w_best_next  = r_best;
        w_idx_next   = r_best_idx;
        w_cnt_next   = r_beat_cnt;
        if (r_sof) begin
            w_best_next = s_axis_tdata;
            w_idx_next  = '0;
            w_cnt_next  = CNT_ONE;
        end else begin
            if (w_in_range && w_better) begin
                w_best_next = s_axis_tdata;
                w_idx_next  = r_beat_cnt[IDX_WIDTH-1:0];
            end
            if (r_beat_cnt != CNT_MAX) begin
                w_cnt_next = r_beat_cnt + CNT_ONE;
            end
        end
    end

    always_comb begin
        w_push      = w_in_fire && (!w_frame_mode || s_axis_tlast);
        w_push_data = s_axis_tdata;
        w_push_keep = s_axis_tkeep;
        w_push_last = s_axis_tlast;
        if (w_frame_mode) begin
            w_push_data = {{(DATA_WIDTH-IDX_WIDTH){1'b0}}, w_idx_next};
            w_push_keep = '1;
            w_push_last = 1'b1;
        end
    end

    // Skid refills from a push only while draining into the output; otherwise a push lands in skid when output is stalled
    always_comb begin
        w_skid_valid_next = r_skid_valid;
        if (w_out_fire && r_skid_valid) begin
            w_skid_valid_next = w_push;
        end else if (w_push && r_out_valid && !w_out_fire) begin
            w_skid_valid_next = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_s_ready    <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_out_keep   <= '0;
            r_out_last   <= 1'b0;
            r_skid_valid <= 1'b0;
            r_skid_data  <= '0;
            r_skid_keep  <= '0;
            r_skid_last  <= 1'b0;
        end else begin
            r_s_ready    <= !w_skid_valid_next;
            r_skid_valid <= w_skid_valid_next;
            if (w_out_fire && r_skid_valid) begin
                r_out_valid <= 1'b1;
                r_out_data  <= r_skid_data;
                r_out_keep  <= r_skid_keep;
                r_out_last  <= r_skid_last;
                if (w_push) begin
                    r_skid_data <= w_push_data;
                    r_skid_keep <= w_push_keep;
                    r_skid_last <= w_push_last;
                end
            end else if (w_push && (!r_out_valid || w_out_fire)) begin
                r_out_valid <= 1'b1;
                r_out_data  <= w_push_data;
                r_out_keep  <= w_push_keep;
                r_out_last  <= w_push_last;
            end else begin
                if (w_push) begin
                    r_skid_data <= w_push_data;
                    r_skid_keep <= w_push_keep;
                    r_skid_last <= w_push_last;
                end
                if (w_out_fire) begin
                    r_out_valid <= 1'b0;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sof         <= 1'b1;
            r_mode        <= 1'b0;
            r_beat_cnt    <= '0;
            r_best        <= '0;
            r_best_idx    <= '0;
            r_frame_count <= '0;
            r_overflow    <= 1'b0;
        end else if (w_in_fire) begin
            r_sof <= s_axis_tlast;
            if (r_sof) begin
                r_mode <= cfg_mode;
            end
            if (s_axis_tlast) begin
                r_frame_count <= r_frame_count + 32'd1;
            end
            if (w_frame_mode) begin
                r_best     <= w_best_next;
                r_best_idx <= w_idx_next;
                r_beat_cnt <= w_cnt_next;
                if (w_ovf_beat) begin
                    r_overflow <= 1'b1;
                end
            end
        end
    end

    assign s_axis_tready    = r_s_ready;
    assign m_axis_tvalid    = r_out_valid;
    assign m_axis_tdata     = r_out_data;
    assign m_axis_tkeep     = r_out_keep;
    assign m_axis_tlast     = r_out_last;
    assign stat_frame_count = r_frame_count;
    assign stat_overflow    = r_overflow;

endmodule

// File: tb/tb_classifier_stream_wrapper.sv
// tb/tb_classifier_stream_wrapper.sv - randomized self-checking bench for classifier_stream_wrapper
module tb_classifier_stream_wrapper;

    localparam int DW = 32;
    localparam int KW = DW / 8;
    localparam int MC = 16;

    typedef struct {
        logic [DW-1:0] data;
        logic [KW-1:0] keep;
        logic          last;
        logic          mode;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_mode = 1'b0;
    logic [DW-1:0] s_axis_tdata = '0;
    logic [KW-1:0] s_axis_tkeep = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tready;
    logic          s_axis_tlast = 1'b0;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tvalid;
    logic          m_axis_tready = 1'b0;
    logic          m_axis_tlast;
    logic [31:0]   stat_frame_count;
    logic          stat_overflow;

    int n_vec = 0;
    int n_err = 0;
    int bp_mode = 3;

    beat_t         cur_q[$];
    beat_t         mon_b;
    logic [DW+KW:0] exp_q[$];
    logic [DW+KW:0] obs_q[$];
    logic [DW-1:0] frame_q[$];
    int            m_frames = 0;
    logic          m_ovf = 1'b0;

    classifier_stream_wrapper #(
        .DATA_WIDTH(DW),
        .KEEP_WIDTH(KW),
        .MAX_CLASSES(MC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .cfg_mode(cfg_mode),
        .s_axis_tdata(s_axis_tdata),
        .s_axis_tkeep(s_axis_tkeep),
        .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tready(s_axis_tready),
        .s_axis_tlast(s_axis_tlast),
        .m_axis_tdata(m_axis_tdata),
        .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready),
        .m_axis_tlast(m_axis_tlast),
        .stat_frame_count(stat_frame_count),
        .stat_overflow(stat_overflow)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: whole frame collected, then judged from the frame-level rules
    function automatic void model_frame();
        int n = cur_q.size();
        int best = 0;
        if (!cur_q[0].mode) begin
            foreach (cur_q[i]) exp_q.push_back({cur_q[i].last, cur_q[i].keep, cur_q[i].data});
        end else begin
            for (int i = 1; i < n && i < MC; i++)
                if ($signed(cur_q[i].data) > $signed(cur_q[best].data)) best = i;
            if (n > MC) m_ovf = 1'b1;
            exp_q.push_back({1'b1, {KW{1'b1}}, DW'(best)});
        end
        m_frames++;
        cur_q.delete();
    endfunction

    initial forever begin
        @(negedge clk);
        if (rst) begin
            cur_q.delete();
            m_frames = 0;
            m_ovf = 1'b0;
        end else begin
            if (m_axis_tvalid && m_axis_tready)
                obs_q.push_back({m_axis_tlast, m_axis_tkeep, m_axis_tdata});
            if (s_axis_tvalid && s_axis_tready) begin
                mon_b.data = s_axis_tdata;
                mon_b.keep = s_axis_tkeep;
                mon_b.last = s_axis_tlast;
                mon_b.mode = cfg_mode;
                cur_q.push_back(mon_b);
                if (s_axis_tlast) model_frame();
            end
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        case (bp_mode)
            0: m_axis_tready = 1'b1;
            1: m_axis_tready = ($urandom_range(0, 3) != 0);
            2: m_axis_tready = 1'b0;
            default: ;
        endcase
    end

    task automatic gap(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input logic [KW-1:0] k, input logic l, input logic md);
        int cyc = 0;
        s_axis_tdata  = d;
        s_axis_tkeep  = k;
        s_axis_tlast  = l;
        cfg_mode      = md;
        s_axis_tvalid = 1'b1;
        @(negedge clk);
        while (!s_axis_tready && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("s_tready_wait", s_axis_tready, 1);
        @(posedge clk);
        #1;
        s_axis_tvalid = 1'b0;
    endtask

    task automatic send_frame(input logic md);
        for (int i = 0; i < frame_q.size(); i++)
            send_beat(frame_q[i], {KW{1'b1}}, (i == frame_q.size() - 1), md);
    endtask

    task automatic drain();
        int cyc = 0;
        bp_mode = 0;
        @(negedge clk);
        while (m_axis_tvalid && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check_eq("drain", m_axis_tvalid, 0);
        @(posedge clk);
        #1;
    endtask

    task automatic check_phase(input string tag);
        check_eq({tag, "_nbeats"}, obs_q.size(), exp_q.size());
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++)
            check_eq({tag, "_beat"}, obs_q[i], exp_q[i]);
        check_eq({tag, "_frames"}, stat_frame_count, m_frames);
        check_eq({tag, "_ovf"}, stat_overflow, m_ovf);
        obs_q.delete();
        exp_q.delete();
    endtask

    task automatic do_reset();
        s_axis_tvalid = 1'b0;
        rst = 1'b1;
        gap(2);
        rst = 1'b0;
        gap(1);
    endtask

    initial begin
        logic md;
        int   len;
        logic [DW-1:0] d;

        repeat (3) @(negedge clk);
        check_eq("rst_s_tready", s_axis_tready, 0);
        check_eq("rst_m_tvalid", m_axis_tvalid, 0);
        check_eq("rst_m_tdata", m_axis_tdata, 0);
        check_eq("rst_m_tkeep", m_axis_tkeep, 0);
        check_eq("rst_m_tlast", m_axis_tlast, 0);
        check_eq("rst_frames", stat_frame_count, 0);
        check_eq("rst_ovf", stat_overflow, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check_eq("rel_s_tready_pre", s_axis_tready, 0);
        @(posedge clk);
        #1;
        check_eq("rel_s_tready", s_axis_tready, 1);

        bp_mode = 0;
        m_axis_tready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            send_beat(DW'(i), {KW{1'b1}}, (i == 7), 1'b0);
            check_eq("pass_lat_valid", m_axis_tvalid, 1);
            check_eq("pass_lat_data", m_axis_tdata, i);
        end
        drain();
        check_phase("pass");
        check_eq("pass_frames_const", stat_frame_count, 1);

        bp_mode = 3;
        m_axis_tready = 1'b0;
        send_beat(32'h100, {KW{1'b1}}, 1'b0, 1'b0);
        send_beat(32'h101, {KW{1'b1}}, 1'b0, 1'b0);
        check_eq("bp_s_tready_low", s_axis_tready, 0);
        check_eq("bp_hold_data", m_axis_tdata, 32'h100);
        gap(5);
        check_eq("bp_s_tready_still_low", s_axis_tready, 0);
        m_axis_tready = 1'b1;
        for (int i = 2; i < 8; i++)
            send_beat(32'h100 + DW'(i), KW'($urandom), (i == 7), 1'b0);
        drain();
        check_phase("bp");

        frame_q = '{32'hFFFF_FFFB, 32'd7, 32'd3, 32'd7, 32'hFFFF_FF9C};
        send_frame(1'b1);
        check_eq("amax_valid", m_axis_tvalid, 1);
        check_eq("amax_tdata", m_axis_tdata, 1);
        check_eq("amax_tkeep", m_axis_tkeep, {KW{1'b1}});
        check_eq("amax_tlast", m_axis_tlast, 1);
        frame_q = '{32'hFFFF_FFF7, 32'hFFFF_FFFE, 32'hFFFF_FFFC};
        send_frame(1'b1);
        check_eq("amax_neg_tdata", m_axis_tdata, 1);
        drain();
        check_phase("amax");

        frame_q.delete();
        for (int i = 0; i < 18; i++) frame_q.push_back(DW'($urandom_range(0, 1000)));
        frame_q[3] = 32'd2000;
        frame_q[16] = 32'd3000;
        frame_q[17] = 32'h7FFF_FFFF;
        send_frame(1'b1);
        check_eq("ovf_idx", m_axis_tdata, 3);
        check_eq("ovf_flag", stat_overflow, 1);
        frame_q = '{32'd1, 32'd2};
        send_frame(1'b1);
        check_eq("ovf_sticky", stat_overflow, 1);
        drain();
        check_phase("ovf");

        do_reset();
        send_beat(32'hA0, {KW{1'b1}}, 1'b0, 1'b0);
        send_beat(32'hA1, 4'h3, 1'b0, 1'b1);
        send_beat(32'hA2, 4'h1, 1'b1, 1'b1);
        send_beat(32'd3, {KW{1'b1}}, 1'b0, 1'b1);
        send_beat(32'd9, {KW{1'b1}}, 1'b0, 1'b0);
        send_beat(32'd9, {KW{1'b1}}, 1'b0, 1'b0);
        send_beat(32'd1, {KW{1'b1}}, 1'b1, 1'b0);
        check_eq("mode_amax_idx", m_axis_tdata, 1);
        send_beat(32'hB0, 4'hC, 1'b0, 1'b0);
        send_beat(32'hB1, 4'hF, 1'b1, 1'b1);
        drain();
        check_phase("mode");
        check_eq("mode_frames_const", stat_frame_count, 3);

        send_beat(32'd5, {KW{1'b1}}, 1'b0, 1'b1);
        send_beat(32'd50, {KW{1'b1}}, 1'b0, 1'b1);
        send_beat(32'd7, {KW{1'b1}}, 1'b0, 1'b1);
        do_reset();
        check_eq("mfr_no_output", m_axis_tvalid, 0);
        frame_q = '{32'd10, 32'd20};
        send_frame(1'b1);
        check_eq("mfr_idx", m_axis_tdata, 1);
        drain();
        check_phase("mfr");

        bp_mode = 1;
        for (int f = 0; f < 40; f++) begin
            md  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 20);
            for (int b = 0; b < len; b++) begin
                gap(($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
                d = ($urandom_range(0, 1) != 0) ? DW'($urandom) : DW'($urandom_range(0, 6)) - DW'(3);
                send_beat(d, KW'($urandom), (b == len - 1), (b == 0) ? md : 1'($urandom_range(0, 1)));
            end
        end
        drain();
        check_phase("rand");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
